// File: rtl/dsp_pkg.sv
// Shared types and constants for the DSP48A1-style MAC control path.
package dsp_pkg;

    typedef struct packed {
        logic first;
        logic last;
    } mac_tag_t;

    typedef enum logic {
        GRP_IDLE = 1'b0,
        GRP_OPEN = 1'b1
    } grp_state_t;

    localparam logic Z_ZERO = 1'b0;
    localparam logic Z_PFB  = 1'b1;

    function automatic int mac_latency(input int abreg, input int mreg);
        return abreg + mreg + 1;
    endfunction

endpackage

// File: rtl/dsp_mac_seq_if.sv
// Handshake and datapath-control bundle between dsp_mac_seq and its neighbours.
interface dsp_mac_seq_if;

    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        ce_ab;
    logic        ce_m;
    logic        ce_p;
    logic        z_sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] grp_count;
    logic        busy;

    modport master (
        output in_valid, in_last, out_ready,
        input  in_ready, ce_ab, ce_m, ce_p, z_sel, out_valid, grp_count, busy
    );

    modport slave (
        input  in_valid, in_last, out_ready,
        output in_ready, ce_ab, ce_m, ce_p, z_sel, out_valid, grp_count, busy
    );

endinterface

// File: rtl/dsp_stage_tag.sv
// Occupancy tracker for one optional datapath register stage: valid bit plus {first,last} tag.
module dsp_stage_tag
    import dsp_pkg::*;
#(
    parameter bit REG = 1'b1
) (
    input  logic     CLK,
    input  logic     RST,
    input  logic     en,
    input  logic     in_v,
    input  mac_tag_t in_tag,
    output logic     out_v,
    output mac_tag_t out_tag
);

    if (REG) begin : g_reg
        // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                out_v   <= 1'b0;
                out_tag <= '0;
            end else if (en) begin
                out_v   <= in_v;
                out_tag <= in_tag;
            end
        end
    end else begin : g_byp
        logic unused_byp;
        assign unused_byp = ^{CLK, RST, en};
        assign out_v      = in_v;
        assign out_tag    = in_tag;
    end

endmodule

// File: rtl/dsp_mac_seq.sv
// Control sequencer for the A/B -> M -> P multiply-accumulate pipeline: drives stage
// enables and the Z-mux select, and hands completed accumulation results downstream.
module dsp_mac_seq
    import dsp_pkg::*;
#(
    parameter int ABREG = 1,
    parameter int MREG  = 1
) (
    input logic          CLK,
    input logic          RST,
    dsp_mac_seq_if.slave bus
);

    grp_state_t  grp_state;
    grp_state_t  grp_next;
    logic        advance;
    logic        accept;
    logic        ab_in_v;
    logic        ab_out_v;
    logic        m_out_v;
    mac_tag_t    ab_in_tag;
    mac_tag_t    ab_out_tag;
    mac_tag_t    m_out_tag;
    logic        v_p;
    logic        l_p;
    logic [15:0] grp_count_q;

    // A pending result that downstream is not taking freezes the whole pipeline.
    assign advance = !(bus.out_valid && !bus.out_ready);
    assign accept  = bus.in_valid && advance;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) grp_state <= GRP_IDLE;
        else     grp_state <= grp_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns grp_next and no latch is inferred.
        grp_next = grp_state;
        if (accept) grp_next = bus.in_last ? GRP_IDLE : GRP_OPEN;
    end

    // Tags are zero whenever the slot is empty, so an idle P input reads as "not first".
    always_comb begin
        ab_in_v   = bus.in_valid;
        ab_in_tag = '0;
        if (bus.in_valid) begin
            ab_in_tag.first = (grp_state == GRP_IDLE);
            ab_in_tag.last  = bus.in_last;
        end
    end

    dsp_stage_tag #(.REG(ABREG != 0)) u_stage_ab (
        .CLK     (CLK),
        .RST     (RST),
        .en      (advance),
        .in_v    (ab_in_v),
        .in_tag  (ab_in_tag),
        .out_v   (ab_out_v),
        .out_tag (ab_out_tag)
    );

    dsp_stage_tag #(.REG(MREG != 0)) u_stage_m (
        .CLK     (CLK),
        .RST     (RST),
        .en      (advance),
        .in_v    (ab_out_v),
        .in_tag  (ab_out_tag),
        .out_v   (m_out_v),
        .out_tag (m_out_tag)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v_p <= 1'b0;
            l_p <= 1'b0;
        end else if (advance) begin
            v_p <= m_out_v;
            l_p <= m_out_tag.last;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                                grp_count_q <= 16'h0000;
        else if (bus.out_valid && bus.out_ready) grp_count_q <= grp_count_q + 16'd1;
    end

    assign bus.in_ready  = advance;
    assign bus.ce_ab     = (ABREG != 0) && advance && ab_in_v;
    assign bus.ce_m      = (MREG != 0) && advance && ab_out_v;
    assign bus.ce_p      = advance && m_out_v;
    assign bus.z_sel     = m_out_tag.first ? Z_ZERO : Z_PFB;
    assign bus.out_valid = v_p && l_p;
    assign bus.grp_count = grp_count_q;
    assign bus.busy      = ((ABREG != 0) && ab_out_v) || ((MREG != 0) && m_out_v) ||
                           v_p || (grp_state == GRP_OPEN);

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Bench for dsp_mac_seq: four pipeline configurations against a tick-based reference model.
module tb_dsp_mac_seq;
    import dsp_pkg::*;

    localparam int NCFG        = 4;
    localparam int WRAP_GROUPS = 65536;

    typedef struct {
        int cfg;
        int at;
        bit first;
        bit last;
    } smp_t;

    typedef struct {
        int          cfg;
        logic [15:0] cnt;
    } grp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv     [NCFG];
    logic        il     [NCFG];
    logic        ordy   [NCFG];
    logic        d_irdy [NCFG];
    logic        d_ceab [NCFG];
    logic        d_cem  [NCFG];
    logic        d_cep  [NCFG];
    logic        d_z    [NCFG];
    logic        d_ov   [NCFG];
    logic        d_busy [NCFG];
    logic [15:0] d_cnt  [NCFG];

    // Reference model: samples are timestamped in advancing cycles ("ticks"); a stall freezes ticks.
    int          tick [NCFG];
    bit          mid  [NCFG];
    bit          ovm  [NCFG];
    bit          vpm  [NCFG];
    logic [15:0] cnt  [NCFG];
    smp_t        pend [$];
    grp_t        gq   [$];

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic int ab_of(input int g);
        return (g == 0 || g == 2) ? 1 : 0;
    endfunction

    function automatic int m_of(input int g);
        return (g == 0 || g == 3) ? 1 : 0;
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int A = (g == 0 || g == 2) ? 1 : 0;
        localparam int M = (g == 0 || g == 3) ? 1 : 0;
        dsp_mac_seq_if bus ();
        dsp_mac_seq #(.ABREG(A), .MREG(M)) dut (
            .CLK (clk),
            .RST (rst),
            .bus (bus.slave)
        );
        assign bus.in_valid  = iv[g];
        assign bus.in_last   = il[g];
        assign bus.out_ready = ordy[g];
        assign d_irdy[g]     = bus.in_ready;
        assign d_ceab[g]     = bus.ce_ab;
        assign d_cem[g]      = bus.ce_m;
        assign d_cep[g]      = bus.ce_p;
        assign d_z[g]        = bus.z_sel;
        assign d_ov[g]       = bus.out_valid;
        assign d_busy[g]     = bus.busy;
        assign d_cnt[g]      = bus.grp_count;
    end

    task automatic check(input string name, input int g, input logic [15:0] act,
                         input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s cfg%0d (AB=%0d M=%0d): got %0h expected %0h at %0t",
                         name, g, ab_of(g), m_of(g), act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < NCFG; g++) begin
            tick[g] = 0;
            mid[g]  = 1'b0;
            ovm[g]  = 1'b0;
            vpm[g]  = 1'b0;
            cnt[g]  = 16'h0000;
        end
        pend.delete();
        gq.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        for (int g = 0; g < NCFG; g++) begin
            check({tag, "_in_ready"},  g, d_irdy[g], 1);
            check({tag, "_ce_ab"},     g, d_ceab[g], 0);
            check({tag, "_ce_m"},      g, d_cem[g],  0);
            check({tag, "_ce_p"},      g, d_cep[g],  0);
            check({tag, "_z_sel"},     g, d_z[g],    1);
            check({tag, "_out_valid"}, g, d_ov[g],   0);
            check({tag, "_busy"},      g, d_busy[g], 0);
            check({tag, "_grp_count"}, g, d_cnt[g],  16'h0000);
        end
    endtask

    // Evaluated between edges: compare this cycle's outputs, then advance the model past the next edge.
    task automatic model_cycle();
        for (int g = 0; g < NCFG; g++) begin
            int a;
            int m;
            int npend;
            int pidx;
            bit adv;
            bit acc;
            bit ce_m_e;
            a     = ab_of(g);
            m     = m_of(g);
            adv   = !(ovm[g] && !ordy[g]);
            acc   = iv[g] && adv;
            npend = 0;
            foreach (pend[i]) if (pend[i].cfg == g) npend++;

            check("in_ready",  g, d_irdy[g], adv);
            check("out_valid", g, d_ov[g],   ovm[g]);
            check("busy",      g, d_busy[g], mid[g] || vpm[g] || (npend > 0));
            check("grp_count", g, d_cnt[g],  cnt[g]);

            if (acc) begin
                pend.push_back('{cfg: g, at: tick[g], first: !mid[g], last: il[g]});
                mid[g] = !il[g];
            end

            ce_m_e = 1'b0;
            pidx   = -1;
            foreach (pend[i]) begin
                if (pend[i].cfg == g) begin
                    if (m == 1 && pend[i].at + a == tick[g]) ce_m_e = adv;
                    if (pend[i].at + a + m == tick[g])       pidx   = i;
                end
            end

            check("ce_ab", g, d_ceab[g], (a == 1) && acc);
            check("ce_m",  g, d_cem[g],  ce_m_e);
            check("ce_p",  g, d_cep[g],  adv && (pidx >= 0));
            if (adv && pidx >= 0) check("z_sel", g, d_z[g], !pend[pidx].first);

            if (ovm[g] && ordy[g]) cnt[g] = cnt[g] + 16'd1;
            if (adv) begin
                if (pidx >= 0) begin
                    vpm[g] = 1'b1;
                    ovm[g] = pend[pidx].last;
                    if (pend[pidx].last) gq.push_back('{cfg: g, cnt: cnt[g]});
                    pend.delete(pidx);
                end else begin
                    vpm[g] = 1'b0;
                    ovm[g] = 1'b0;
                end
                tick[g]++;
            end
        end
    endtask

    task automatic cycle(input bit v, input bit l, input bit r);
        @(posedge clk);
        #1;
        for (int g = 0; g < NCFG; g++) begin
            iv[g]   = v;
            il[g]   = l;
            ordy[g] = r;
        end
        @(negedge clk);
        model_cycle();
    endtask

    task automatic rcycle();
        @(posedge clk);
        #1;
        for (int g = 0; g < NCFG; g++) begin
            iv[g]   = ($urandom_range(0, 3) != 0);
            il[g]   = ($urandom_range(0, 2) == 0);
            ordy[g] = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        model_cycle();
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        for (int g = 0; g < NCFG; g++) begin
            iv[g]   = 1'b0;
            il[g]   = 1'b0;
            ordy[g] = 1'b1;
        end
        #2 rst = 1'b1;
        #1 check_reset_vals(tag);
        model_reset();
        #2 rst = 1'b0;
    endtask

    // Scoreboard monitor: every handoff must match the oldest expected result of that configuration.
    always @(negedge clk) begin
        int k;
        if (rst === 1'b0) begin
            for (int g = 0; g < NCFG; g++) begin
                if (d_ov[g] === 1'b1 && ordy[g] === 1'b1) begin
                    k = -1;
                    for (int i = 0; i < gq.size(); i++)
                        if (k < 0 && gq[i].cfg == g) k = i;
                    if (k < 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL handoff cfg%0d: out_valid=1 but no result expected at %0t",
                                 g, $time);
                    end else begin
                        check("grp_count_at_handoff", g, d_cnt[g], gq[k].cnt);
                        gq.delete(k);
                    end
                end
            end
        end
    end

    initial begin
        int drain;
        int left;
        drain = mac_latency(1, 1) + 3;
        rst   = 1'b1;
        for (int g = 0; g < NCFG; g++) begin
            iv[g]   = 1'b0;
            il[g]   = 1'b0;
            ordy[g] = 1'b1;
        end
        model_reset();
        #3 check_reset_vals("por");
        #9 rst = 1'b0;

        // Four-sample group, back to back.
        repeat (3) cycle(1, 0, 1);
        cycle(1, 1, 1);
        repeat (drain) cycle(0, 0, 1);

        // Five one-sample groups in a row.
        repeat (5) cycle(1, 1, 1);
        repeat (drain) cycle(0, 0, 1);

        // Stall with input still offered, then release.
        repeat (8) cycle(1, 1, 0);
        repeat (4) cycle(1, 1, 1);
        repeat (drain) cycle(0, 0, 1);

        // Group with idle gaps between samples.
        cycle(1, 0, 1);
        repeat (2) cycle(0, 0, 1);
        cycle(1, 0, 1);
        repeat (3) cycle(0, 0, 1);
        cycle(1, 1, 1);
        repeat (drain) cycle(0, 0, 1);

        repeat (2000) rcycle();
        repeat (drain) cycle(0, 0, 1);

        // Reset with samples in flight and a group open.
        cycle(1, 0, 1);
        cycle(1, 0, 1);
        do_reset("midop");
        cycle(1, 1, 1);
        repeat (drain) cycle(0, 0, 1);

        // Counter wrap through 65536 one-sample groups.
        do_reset("prewrap");
        repeat (WRAP_GROUPS) cycle(1, 1, 1);
        repeat (drain) cycle(0, 0, 1);

        for (int g = 0; g < NCFG; g++) begin
            check("grp_count_wrap", g, d_cnt[g], 16'h0000);
            left = 0;
            foreach (gq[i]) if (gq[i].cfg == g) left++;
            check("results_not_handed_off", g, left[15:0], 16'h0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
